// File: rtl/priority_4to2.sv
// -----------------------------------------------------------------------------
// priority_4to2
//
// Registered 4-to-2 priority encoder. On each rising clock edge the request
// vector w is sampled. y takes the binary index of the highest set bit, with
// w[3] the highest priority. valid flags that at least one bit was set. Both
// outputs come straight from flip-flops, so there is no combinational path
// from w to y or valid. A new w is accepted every cycle.
//
// Ports:
//   clk    in   1  clock; all state updates on the rising edge
//   rst_n  in   1  synchronous active-low reset; clears y and valid
//   w      in   4  request vector, w[3] highest priority
//   y      out  2  registered index of the highest-priority set bit of w
//   valid  out  1  registered "any bit of w set"
// -----------------------------------------------------------------------------
module priority_4to2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] w,
    output logic [1:0] y,
    output logic       valid
);

    logic [1:0] y_d;
    logic [1:0] y_q;
    logic       valid_d;
    logic       valid_q;

    // Priority encode. An empty w gives y=00 like w=0001 does, so valid is
    // the only way to tell "no request" from "request on bit 0".
    always_comb begin
        y_d     = 2'b00;
        valid_d = |w;
        if (w[3]) begin
            y_d = 2'b11;
        end else if (w[2]) begin
            y_d = 2'b10;
        end else if (w[1]) begin
            y_d = 2'b01;
        end else begin
            y_d = 2'b00;
        end
    end

    // Reset is sampled only on the clock edge. Reset asserted between edges
    // leaves the outputs alone until the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_4to2.sv
module tb_priority_4to2;

    logic       clk;
    logic       rst_n;
    logic [3:0] w;
    logic [1:0] y;
    logic       valid;

    int compared;
    int mismatched;

    // Hand-computed {valid, y} for w = 0..15.
    logic [2:0] exp_tab [16];

    priority_4to2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w     (w),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] ey, input logic ev);
        compared++;
        assert (y === ey) else begin
            mismatched++;
            $error("FAIL %s: y observed %b expected %b", tag, y, ey);
        end
        compared++;
        assert (valid === ev) else begin
            mismatched++;
            $error("FAIL %s: valid observed %b expected %b", tag, valid, ev);
        end
    endtask

    // Apply inputs, then sample 1 time unit after the next rising edge.
    task automatic step(input logic rst_v, input logic [3:0] w_v);
        rst_n = rst_v;
        w     = w_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        exp_tab = '{3'b000, 3'b100, 3'b101, 3'b101,
                    3'b110, 3'b110, 3'b110, 3'b110,
                    3'b111, 3'b111, 3'b111, 3'b111,
                    3'b111, 3'b111, 3'b111, 3'b111};
        rst_n = 1'b0;
        w     = 4'b1111;
        #2;

        // Reset for 2 cycles with w all-ones, then release with idle w.
        step(1'b0, 4'b1111);
        check("reset_c1", 2'b00, 1'b0);
        step(1'b0, 4'b1111);
        check("reset_c2", 2'b00, 1'b0);
        step(1'b1, 4'b0000);
        check("release_idle", 2'b00, 1'b0);

        // One-hot sweep.
        step(1'b1, 4'b0001);
        check("onehot_0001", 2'b00, 1'b1);
        step(1'b1, 4'b0010);
        check("onehot_0010", 2'b01, 1'b1);
        step(1'b1, 4'b0100);
        check("onehot_0100", 2'b10, 1'b1);
        step(1'b1, 4'b1000);
        check("onehot_1000", 2'b11, 1'b1);

        // Lower bits ignored when a higher bit is set.
        step(1'b1, 4'b1010);
        check("prio_1010", 2'b11, 1'b1);
        step(1'b1, 4'b0111);
        check("prio_0111", 2'b10, 1'b1);
        step(1'b1, 4'b0011);
        check("prio_0011", 2'b01, 1'b1);

        // Mid-cycle change of w must not reach the outputs before the edge.
        step(1'b1, 4'b0001);
        check("glitch_pre", 2'b00, 1'b1);
        #3;
        w = 4'b1000;
        #1;
        check("glitch_hold", 2'b00, 1'b1);
        @(posedge clk);
        #1;
        check("glitch_edge", 2'b11, 1'b1);

        // Synchronous reset asserted mid-cycle while valid=1.
        #3;
        rst_n = 1'b0;
        #1;
        check("sync_rst_hold", 2'b11, 1'b1);
        @(posedge clk);
        #1;
        check("sync_rst_edge", 2'b00, 1'b0);
        step(1'b1, 4'b0100);
        check("sync_rst_release", 2'b10, 1'b1);

        // Exhaustive sweep, one value per cycle.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i));
            check($sformatf("exh_%0d", i), exp_tab[i][1:0], exp_tab[i][2]);
        end

        // Back to idle after a request.
        step(1'b1, 4'b0000);
        check("final_idle", 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/priority_4to2.md
PRIORITY_4TO2 -- requirements
Module: priority_4to2

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset, synchronous, active-low; sampled only on rising clk.
REQ-003: w  input  4  request vector; w[3] highest priority, w[0] lowest.
REQ-004: y  output  2  binary index of highest-priority asserted bit of w, registered.
REQ-005: valid  output  1  high when at least one bit of w was asserted, registered.
REQ-006: Port order SHALL be clk, rst_n, w, y, valid; no parameters.

Function
REQ-007: Encoding SHALL be evaluated on w as sampled at each rising clk edge with rst_n high:
- w[3]=1 -> y=2'b11, valid=1
- w[3]=0, w[2]=1 -> y=2'b10, valid=1
- w[3:2]=0, w[1]=1 -> y=2'b01, valid=1
- w[3:1]=0, w[0]=1 -> y=2'b00, valid=1
- w=4'b0000 -> y=2'b00, valid=0
REQ-008: Lower-priority bits SHALL be ignored whenever a higher bit is set (e.g., 4'b1010 -> 11, 4'b0111 -> 10, 4'b0011 -> 01).
REQ-009: Latency SHALL be exactly one clk cycle: w sampled at edge N appears on y/valid after edge N and holds until edge N+1.
REQ-010: y and valid SHALL be driven directly from flip-flops, with no combinational path from w to the outputs.
REQ-011: y=2'b00 with valid=0 (no request) SHALL be distinguishable from y=2'b00 with valid=1 (w[0] only) solely by valid.
REQ-012: A change of w between clock edges SHALL NOT affect the outputs until the next rising edge.
REQ-013: No handshake: the block SHALL accept a new w every cycle with no stall or backpressure.

Reset
REQ-014: When rst_n=0 at a rising clk edge, y SHALL become 2'b00 and valid SHALL become 0, regardless of w.
REQ-015: Reset SHALL NOT act asynchronously: asserting rst_n between edges SHALL leave the outputs unchanged until the next rising edge.
REQ-016: On the first rising edge with rst_n=1, the outputs SHALL reflect w sampled at that edge; no extra recovery cycles.
REQ-017: Reset asserted mid-stream (valid=1) SHALL clear the outputs at the next edge; the pre-reset w value SHALL NOT be retained.

Verification
REQ-018: Reset then idle: rst_n=0 for 2 cycles with w=4'b1111 -> y=00, valid=0; release with w=4'b0000 -> y=00, valid=0.
REQ-019: One-hot sweep, one value per cycle: w=0001, 0010, 0100, 1000 -> y=00, 01, 10, 11 each one cycle later, valid=1.
REQ-020: Priority: w=1010 -> y=11; w=0111 -> y=10; w=0011 -> y=01; valid=1 in all cases.
REQ-021: Latency/glitch check: change w mid-cycle from 0001 to 1000 -> outputs hold 00/1 until the next edge, then show 11/1.
REQ-022: Synchronous reset mid-stream: w=1000 with valid=1, pull rst_n low mid-cycle -> outputs unchanged until the edge, then 00/0; release with w=0100 -> y=10, valid=1 after one edge.
REQ-023: Exhaustive: all 16 values of w, with the output checked one cycle later against REQ-007.
